// File: rtl/sevenseg_capture.sv
// Observes a multiplexed active-low seven-segment bus, decodes each digit back to a hex nibble
// and commits it once STABLE identical samples have been seen on that digit.
module sevenseg_capture #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned STABLE = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_en,
    input  logic [DIGITS-1:0]     an,
    input  logic [6:0]            seg,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_blank,
    output logic                  update,
    output logic                  frame_valid,
    output logic                  seg_err,
    output logic                  scan_err
);

    localparam int unsigned CW = $clog2(STABLE + 1);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] STABLE_C = CW'(STABLE);

    logic [4:0]          r_cand [DIGITS];
    logic [DIGITS-1:0]   r_cand_vld;
    logic [CW-1:0]       r_cnt  [DIGITS];
    logic [DIGITS-1:0]   r_committed;
    logic [4*DIGITS-1:0] r_value;
    logic [DIGITS-1:0]   r_blank;
    logic                r_update;
    logic                r_frame_valid;
    logic                r_seg_err;
    logic                r_scan_err;

    logic                w_dec_vld;
    logic [4:0]          w_code;
    logic [DIGITS-1:0]   w_low;
    logic                w_any;
    logic                w_multi;
    logic [IW-1:0]       w_idx;
    logic                w_sample_ok;
    logic                w_sample_bad;
    logic                w_scan_err;
    logic                w_match;
    logic [CW-1:0]       w_cur_cnt;
    logic [CW-1:0]       w_cnt_next;
    logic                w_commit;
    logic [3:0]          w_old_nib;
    logic [3:0]          w_new_nib;
    logic                w_changed;
    logic [DIGITS-1:0]   w_committed_next;

    // Code layout: bit4 = blank, bits3:0 = nibble.
    always_comb begin
        w_dec_vld = 1'b1;
        w_code    = 5'h00;
        case (seg)
            7'h40: w_code = 5'h00;
            7'h79: w_code = 5'h01;
            7'h24: w_code = 5'h02;
            7'h30: w_code = 5'h03;
            7'h19: w_code = 5'h04;
            7'h12: w_code = 5'h05;
            7'h02: w_code = 5'h06;
            7'h78: w_code = 5'h07;
            7'h00: w_code = 5'h08;
            7'h18: w_code = 5'h09;
            7'h08: w_code = 5'h0A;
            7'h03: w_code = 5'h0B;
            7'h46: w_code = 5'h0C;
            7'h21: w_code = 5'h0D;
            7'h06: w_code = 5'h0E;
            7'h0E: w_code = 5'h0F;
            7'h7F: w_code = 5'h10;
            default: w_dec_vld = 1'b0;
        endcase
    end

    always_comb begin
        w_low   = ~an;
        w_any   = |w_low;
        w_multi = (w_low & (w_low - DIGITS'(1))) != '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (w_low[i]) w_idx = IW'(i);
        end
    end

    always_comb begin
        w_sample_ok  = sample_en && w_any && !w_multi && w_dec_vld;
        w_sample_bad = sample_en && w_any && !w_multi && !w_dec_vld;
        w_scan_err   = sample_en && w_multi;

        w_cur_cnt = r_cnt[w_idx];
        w_match   = r_cand_vld[w_idx] && (r_cand[w_idx] == w_code);
        if (w_match)
            w_cnt_next = (w_cur_cnt == STABLE_C) ? w_cur_cnt : w_cur_cnt + CW'(1);
        else
            w_cnt_next = CW'(1);

        // A saturated counter that sees yet another match has already committed.
        w_commit = w_sample_ok && (w_cnt_next == STABLE_C)
                   && !(w_match && (w_cur_cnt == STABLE_C));

        w_old_nib = r_value[4*w_idx +: 4];
        w_new_nib = w_code[4] ? w_old_nib : w_code[3:0];
        w_changed = (w_new_nib != w_old_nib) || (w_code[4] != r_blank[w_idx]);

        w_committed_next = r_committed | (w_commit ? w_low : '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DIGITS; i++) begin
                r_cand[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_cand_vld    <= '0;
            r_committed   <= '0;
            r_value       <= '0;
            r_blank       <= '1;
            r_update      <= 1'b0;
            r_frame_valid <= 1'b0;
            r_seg_err     <= 1'b0;
            r_scan_err    <= 1'b0;
        end else begin
            r_update   <= w_commit && w_changed;
            r_seg_err  <= w_sample_bad;
            r_scan_err <= w_scan_err;
            if (w_sample_ok) begin
                r_cand[w_idx]     <= w_code;
                r_cand_vld[w_idx] <= 1'b1;
                r_cnt[w_idx]      <= w_cnt_next;
            end
            if (w_sample_bad) begin
                r_cand_vld[w_idx] <= 1'b0;
                r_cnt[w_idx]      <= '0;
            end
            if (w_commit) begin
                r_value[4*w_idx +: 4] <= w_new_nib;
                r_blank[w_idx]        <= w_code[4];
            end
            r_committed   <= w_committed_next;
            r_frame_valid <= r_frame_valid | (&w_committed_next);
        end
    end

    assign value       = r_value;
    assign digit_blank = r_blank;
    assign update      = r_update;
    assign frame_valid = r_frame_valid;
    assign seg_err     = r_seg_err;
    assign scan_err    = r_scan_err;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture (DIGITS=4, STABLE=3) with hand-computed expectations.
module tb_sevenseg_capture;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sample_en = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [6:0]  seg = 7'h7F;
    logic [15:0] value;
    logic [3:0]  digit_blank;
    logic        update, frame_valid, seg_err, scan_err;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_upd;

    sevenseg_capture #(.DIGITS(4), .STABLE(3)) dut (
        .clk(clk), .reset(reset), .sample_en(sample_en), .an(an), .seg(seg),
        .value(value), .digit_blank(digit_blank), .update(update),
        .frame_valid(frame_valid), .seg_err(seg_err), .scan_err(scan_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic strobe(input logic [3:0] a, input logic [6:0] s);
        @(negedge clk);
        sample_en = 1'b1;
        an = a;
        seg = s;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
        if (update) n_upd++;
    endtask

    task automatic idle();
        @(negedge clk);
        sample_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] dsel(input int unsigned d);
        logic [3:0] m;
        m = 4'hF;
        m[d] = 1'b0;
        return m;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_value"}, value, 16'h0000);
        check({tag, "_blank"}, digit_blank, 4'hF);
        check({tag, "_fv"}, frame_valid, 0);
        check({tag, "_pulses"}, {update, seg_err, scan_err}, 3'b000);
    endtask

    initial begin
        logic [6:0] pat [4];
        pat[3] = 7'h08; pat[2] = 7'h12; pat[1] = 7'h46; pat[0] = 7'h79;

        // Reset held with bus activity
        sample_en = 1'b1; an = 4'b1110; seg = 7'h08;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
        sample_en = 1'b0;

        // Three scan passes, digits 3..0 -> A5C1
        n_upd = 0;
        for (int p = 0; p < 2; p++)
            for (int d = 3; d >= 0; d--) strobe(dsel(d), pat[d]);
        check("no_upd_before_third", n_upd, 0);
        check("fv_before_third", frame_valid, 0);
        for (int d = 3; d >= 0; d--) begin
            strobe(dsel(d), pat[d]);
            check($sformatf("upd_pass3_d%0d", d), update, 1);
            if (d == 1) check("fv_before_d0", frame_valid, 0);
        end
        check("fv_after_d0", frame_valid, 1);
        check("value_A5C1", value, 16'hA5C1);
        check("blank_0", digit_blank, 4'h0);
        idle();
        check("upd_one_cycle", update, 0);

        // Re-commit of the same value must not pulse
        n_upd = 0;
        strobe(4'b1110, 7'h79); strobe(4'b1110, 7'h79); strobe(4'b1110, 7'h24);
        strobe(4'b1110, 7'h79); strobe(4'b1110, 7'h79); strobe(4'b1110, 7'h79);
        check("recommit_no_upd", n_upd, 0);
        check("recommit_value", value, 16'hA5C1);
        strobe(4'b1110, 7'h24); strobe(4'b1110, 7'h24);
        check("d0_2_not_yet", update, 0);
        strobe(4'b1110, 7'h24);
        check("d0_2_upd", update, 1);
        check("value_A5C2", value, 16'hA5C2);

        // Invalid pattern then blank on digit 2
        strobe(4'b1011, 7'h7E);
        check("seg_err_pulse", seg_err, 1);
        check("seg_err_value", value, 16'hA5C2);
        idle();
        check("seg_err_one_cycle", seg_err, 0);
        strobe(4'b1011, 7'h7F); strobe(4'b1011, 7'h7F);
        check("blank_not_yet", digit_blank, 4'h0);
        strobe(4'b1011, 7'h7F);
        check("blank_upd", update, 1);
        check("blank_bit", digit_blank, 4'b0100);
        check("blank_nibble_held", value, 16'hA5C2);

        // Scan errors and idle anodes
        strobe(4'b0011, 7'h40);
        check("scan_err_pulse", scan_err, 1);
        check("scan_err_no_other", {update, seg_err}, 2'b00);
        idle();
        check("scan_err_one_cycle", scan_err, 0);
        strobe(4'b1111, 7'h7E);
        check("idle_an_no_pulse", {update, seg_err, scan_err}, 3'b000);
        check("idle_an_value", value, 16'hA5C2);
        check("idle_an_blank", digit_blank, 4'b0100);

        // Asynchronous reset mid-accumulation
        strobe(4'b1101, 7'h30); strobe(4'b1101, 7'h30);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        reset = 1'b0;
        strobe(4'b1101, 7'h30); strobe(4'b1101, 7'h30);
        check("post_rst_no_early_commit", update, 0);
        strobe(4'b1101, 7'h30);
        check("post_rst_upd", update, 1);
        check("post_rst_value", value, 16'h0030);
        check("post_rst_blank", digit_blank, 4'b1101);
        check("post_rst_fv", frame_valid, 0);
        for (int k = 0; k < 3; k++) strobe(4'b1110, 7'h40);
        check("d0_zero_blank_upd", update, 1);
        check("fv_after_d0_only", frame_valid, 0);
        for (int k = 0; k < 3; k++) strobe(4'b1011, 7'h19);
        check("fv_after_d2", frame_valid, 0);
        for (int k = 0; k < 3; k++) strobe(4'b0111, 7'h00);
        check("fv_final", frame_valid, 1);
        check("final_value", value, 16'h8430);
        check("final_blank", digit_blank, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
